seq_unlock_fsm: RTL
===================

# seq_unlock_fsm

Parametrised sequence-unlock state machine with hardened state encoding. It accepts a stream of IN_W-bit user codes and compares them against a programmable SEQ_LEN-code sequence. A full match opens a timed unlock window; repeated mismatches force a timed lockout. Any illegal state or index value drives the block into a sticky FAULT state, so no state encoding is left undefined. It sits between the user-input synchroniser and the privilege/enable logic it gates.

## Interface
- IN_W, 3, width of one user code
- SEQ_LEN, 4, number of codes in the unlock sequence (≥1)
- FAIL_MAX, 3, consecutive failed attempts that trigger lockout (≥1)
- UNLOCK_CYC, 8, unlock window length in cycles (≥1)
- LOCKOUT_CYC, 16, lockout length in cycles (≥1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_code is valid this cycle
- in_code  in  IN_W  user code
- cfg_load  in  1  capture seq_cfg into the shadow register (honoured in IDLE only)
- seq_cfg  in  SEQ_LEN*IN_W  sequence; code k occupies bits [k*IN_W +: IN_W]
- clear  in  1  abort the current attempt or close the unlock window
- state_o  out  3  current state encoding
- unlocked  out  1  unlock window active
- locked_out  out  1  lockout active
- fault  out  1  sticky fault
- fail_cnt  out  $clog2(FAIL_MAX+1)  consecutive failed attempts
- match_idx  out  $clog2(SEQ_LEN+1)  codes matched so far

## Operation
- States: IDLE=3'd0, MATCH=3'd1, UNLOCKED=3'd2, LOCKOUT=3'd3, FAULT=3'd7. Encodings 4–6 are illegal.
- Reset values: state IDLE, shadow sequence 0, idx 0, timer 0, fail_cnt 0. All outputs are 0.
- IDLE:
  - cfg_load=1 loads the shadow register.
  - in_valid with in_code==seq[0] goes to MATCH with idx=1. If SEQ_LEN==1, it goes directly to UNLOCKED.
  - in_valid with a mismatch is a failure (see below).
- MATCH:
  - in_valid with in_code==seq[idx] increments idx. When idx reaches SEQ_LEN, the FSM goes to UNLOCKED.
  - A mismatch is a failure.
  - clear returns to IDLE with idx=0 and no fail increment.
- Failure handling: idx←0 and fail_cnt←fail_cnt+1. If the new value equals FAIL_MAX, the FSM goes to LOCKOUT; otherwise it goes to IDLE.
- UNLOCKED:
  - On entry, timer←UNLOCK_CYC-1 and fail_cnt←0.
  - in_valid and cfg_load are ignored.
  - clear, or timer==0, goes to IDLE. Otherwise the timer decrements.
- LOCKOUT:
  - On entry, timer←LOCKOUT_CYC-1.
  - in_valid, clear and cfg_load are ignored.
  - When timer==0, the FSM goes to IDLE and fail_cnt←0.
- FAULT:
  - Entered from an illegal state encoding, from idx>SEQ_LEN, or from a MATCH state with idx==0.
  - Sets fault=1. All inputs are ignored and only rst_n exits this state.
- cfg_load outside IDLE is dropped; it is not queued.
- Priority in IDLE/MATCH: clear > in_valid. In IDLE, a simultaneous cfg_load and in_valid compares in_code against the old shadow value, and the new value takes effect the next cycle.

## Timing
- All outputs are registered and reflect the state after the clock edge.
- Latency from in_valid to state update is one cycle.
- Final matching code sampled at edge t: unlocked=1 over edges t+1 … t+UNLOCK_CYC (exactly UNLOCK_CYC cycles), and IDLE is restored at edge t+UNLOCK_CYC+1.
- Lockout behaves the same way: locked_out=1 for exactly LOCKOUT_CYC cycles.
- clear in UNLOCKED: unlocked falls at the next edge.
- Asserting rst_n at any point, including mid-sequence, mid-window or in FAULT, immediately returns the block to the reset values.
- Back-to-back in_valid every cycle is supported; no bubbles are required.

## Structure
- Package seq_unlock_pkg holds the state enum (3-bit, with the explicit encodings above) and the FAULT-detection helper function.
- One sub-module, seq_timer: a loadable down-counter with a zero flag, shared between UNLOCKED and LOCKOUT.
- The next-state logic uses a default branch that goes to FAULT. No latch-inferring or partial case statements are allowed.

## Test plan
- Load 3,5,1,6; feed 3,5,1,6 on consecutive cycles. Required: match_idx goes 1,2,3 and then unlocked=1 for 8 cycles, followed by IDLE with fail_cnt=0.
- Feed 3,5,2 with the same sequence loaded. Required: fail_cnt=1 and state IDLE. Then feed 3,5,1,6. Required: unlock occurs and fail_cnt=0.
- Three mismatches (code 0 each). Required: fail_cnt=3 and locked_out=1 for 16 cycles. Codes fed during lockout are ignored; lockout then exits with fail_cnt=0.
- During unlock, assert clear at window cycle 3. Required: unlocked falls next edge. In the same cycle, clear together with in_valid drops the code.
- Force the state register to 3'd5 (or idx to 7). Required: fault=1 and state_o=7, persisting through all inputs until rst_n.
- Assert rst_n mid-MATCH (idx=2), and separately assert cfg_load during MATCH. Required: reset clears all outputs asynchronously, and the shadow register is unchanged by the cfg_load.

Source files
------------

// File: rtl/seq_unlock_pkg.sv
// seq_unlock_pkg: state encoding and fault-detection helper for seq_unlock_fsm
package seq_unlock_pkg;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MATCH    = 3'd1,
    S_UNLOCKED = 3'd2,
    S_LOCKOUT  = 3'd3,
    S_FAULT    = 3'd7
  } state_e;

  function automatic logic fault_check(input logic [2:0] st, input int idx, input int len);
    return !(st inside {S_IDLE, S_MATCH, S_UNLOCKED, S_LOCKOUT, S_FAULT}) ||
           idx > len || (st == S_MATCH && idx == 0);
  endfunction
endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter with zero flag, shared by unlock window and lockout
module seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_dec && !o_zero) r_cnt <= r_cnt - 1'b1;
  end
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/seq_unlock_fsm.sv
// seq_unlock_fsm: programmable code-sequence unlock FSM with timed window, lockout and sticky fault
module seq_unlock_fsm
  import seq_unlock_pkg::*;
#(
  parameter int IN_W        = 3,
  parameter int SEQ_LEN     = 4,
  parameter int FAIL_MAX    = 3,
  parameter int UNLOCK_CYC  = 8,
  parameter int LOCKOUT_CYC = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [IN_W-1:0]                in_code,
  input  logic                           cfg_load,
  input  logic [SEQ_LEN*IN_W-1:0]        seq_cfg,
  input  logic                           clear,
  output logic [2:0]                     state_o,
  output logic                           unlocked,
  output logic                           locked_out,
  output logic                           fault,
  output logic [$clog2(FAIL_MAX+1)-1:0]  fail_cnt,
  output logic [$clog2(SEQ_LEN+1)-1:0]   match_idx
);
  localparam int IW   = $clog2(SEQ_LEN+1);
  localparam int FW   = $clog2(FAIL_MAX+1);
  localparam int NS   = 1 << IW;
  localparam int TMAX = UNLOCK_CYC > LOCKOUT_CYC ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;

  logic [2:0]              r_state, w_state_nx;
  logic [IW-1:0]           r_idx, w_idx_nx, w_cur, w_nxt;
  logic [FW-1:0]           r_fail, w_fail_nx, w_fail_inc;
  logic [SEQ_LEN*IN_W-1:0] r_seq, w_seq_nx;
  logic [IN_W-1:0]         w_seq_arr [NS];
  logic                    w_tload, w_tdec, w_tzero;
  logic [TW-1:0]           w_tval;

  // pad the code table to a power of two so any idx value indexes safely
  for (genvar i = 0; i < NS; i++) begin : g_seq
    if (i < SEQ_LEN) begin : g_used
      assign w_seq_arr[i] = r_seq[i*IN_W +: IN_W];
    end else begin : g_pad
      assign w_seq_arr[i] = '0;
    end
  end

  seq_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_tload),
    .i_dec  (w_tdec),
    .i_val  (w_tval),
    .o_zero (w_tzero)
  );

  assign w_cur      = r_state == S_IDLE ? '0 : r_idx;
  assign w_nxt      = w_cur + 1'b1;
  assign w_fail_inc = r_fail + 1'b1;

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_fail_nx  = r_fail;
    w_seq_nx   = r_seq;
    w_tload    = 1'b0;
    w_tdec     = 1'b0;
    w_tval     = '0;
    case (r_state)
      S_IDLE, S_MATCH: begin
        if (r_state == S_IDLE && cfg_load) w_seq_nx = seq_cfg;
        if (clear) begin
          w_state_nx = S_IDLE;
          w_idx_nx   = '0;
        end else if (in_valid && in_code == w_seq_arr[w_cur]) begin
          w_idx_nx = w_nxt;
          if (w_nxt == IW'(SEQ_LEN)) begin
            w_state_nx = S_UNLOCKED;
            w_fail_nx  = '0;
            w_tload    = 1'b1;
            w_tval     = TW'(UNLOCK_CYC - 1);
          end else begin
            w_state_nx = S_MATCH;
          end
        end else if (in_valid) begin
          w_idx_nx   = '0;
          w_fail_nx  = w_fail_inc;
          w_state_nx = w_fail_inc == FW'(FAIL_MAX) ? S_LOCKOUT : S_IDLE;
          w_tload    = w_fail_inc == FW'(FAIL_MAX);
          w_tval     = TW'(LOCKOUT_CYC - 1);
        end
      end
      S_UNLOCKED: begin
        w_tdec     = 1'b1;
        w_state_nx = (clear || w_tzero) ? S_IDLE : S_UNLOCKED;
        w_idx_nx   = (clear || w_tzero) ? '0 : r_idx;
      end
      S_LOCKOUT: begin
        w_tdec     = 1'b1;
        w_state_nx = w_tzero ? S_IDLE : S_LOCKOUT;
        w_fail_nx  = w_tzero ? '0 : r_fail;
      end
      S_FAULT: w_state_nx = S_FAULT;
      default: w_state_nx = S_FAULT;
    endcase
    if (fault_check(r_state, 32'(r_idx), SEQ_LEN)) w_state_nx = S_FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_fail  <= '0;
      r_seq   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_fail  <= w_fail_nx;
      r_seq   <= w_seq_nx;
    end
  end

  assign state_o    = r_state;
  assign unlocked   = r_state == S_UNLOCKED;
  assign locked_out = r_state == S_LOCKOUT;
  assign fault      = r_state == S_FAULT;
  assign fail_cnt   = r_fail;
  assign match_idx  = r_idx;
endmodule
